// File: rtl/costas_pkg.sv
// Shared definitions for the Costas carrier-recovery blocks: state encoding,
// default phase-error width and gain-shift width.
package costas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACQ   = 2'd2,
    ST_TRACK = 2'd3
  } costas_state_t;

  localparam int ERR_W_DEF = 58;
  localparam int SHIFT_W   = 5;

endpackage

// File: rtl/err_window_avg.sv
// Saturating |phase_error| accumulated over 2^WIN_LOG2 accepted samples;
// publishes the window mean with a one-cycle valid pulse.
module err_window_avg
  import costas_pkg::*;
#(
  parameter int ERR_W    = ERR_W_DEF,
  parameter int WIN_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    accept,
  input  logic signed [ERR_W-1:0] phase_error,
  output logic [ERR_W-2:0]        mean_err,
  output logic                    mean_valid
);

  localparam int MAG_W = ERR_W - 1;
  localparam int ACC_W = MAG_W + WIN_LOG2;

  logic [MAG_W-1:0]    mag;
  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    sum;
  logic [WIN_LOG2-1:0] cnt_reg;
  logic                last;

  // Low bits of the two's-complement negation are exact for every value except
  // the most negative one, which has no positive counterpart and saturates.
  always_comb begin
    mag = phase_error[MAG_W-1:0];
    if (phase_error[ERR_W-1]) begin
      if (phase_error[MAG_W-1:0] == '0) mag = '1;
      else                              mag = ~phase_error[MAG_W-1:0] + MAG_W'(1);
    end
  end

  assign sum  = acc_reg + ACC_W'(mag);
  assign last = accept && (cnt_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mean_err   <= '0;
      mean_valid <= 1'b0;
    end else begin
      mean_valid <= last;
      if (clear) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (accept) begin
        if (last) begin
          mean_err <= sum[ACC_W-1:WIN_LOG2];
          acc_reg  <= '0;
          cnt_reg  <= '0;
        end else begin
          acc_reg <= sum;
          cnt_reg <= cnt_reg + WIN_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: rtl/costas_loop_ctrl.sv
// Costas loop acquisition/tracking sequencer: window-mean driven lock FSM with
// hysteresis, gain-shift scheduling and loop-filter clear pulses.
module costas_loop_ctrl
  import costas_pkg::*;
#(
  parameter int ERR_W       = ERR_W_DEF,
  parameter int WIN_LOG2    = 10,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 2,
  parameter int ACQ_TIMEOUT = 64,
  parameter int KP_ACQ_SH   = 4,
  parameter int KI_ACQ_SH   = 8,
  parameter int KP_TRK_SH   = 7,
  parameter int KI_TRK_SH   = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    restart,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] phase_error,
  input  logic [ERR_W-2:0]        lock_thresh,
  input  logic [ERR_W-2:0]        unlock_thresh,
  output logic [SHIFT_W-1:0]      kp_shift,
  output logic [SHIFT_W-1:0]      ki_shift,
  output logic                    loop_clear,
  output logic                    locked,
  output logic                    timeout,
  output logic [1:0]              state,
  output logic [ERR_W-2:0]        mean_err,
  output logic                    mean_valid
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int WIN_W  = $clog2(ACQ_TIMEOUT + 1);

  costas_state_t      state_reg, state_next;
  logic [GOOD_W-1:0]  good_reg, good_next;
  logic [BAD_W-1:0]   bad_reg, bad_next;
  logic [WIN_W-1:0]   win_reg, win_next;
  logic               timeout_evt;
  logic               loop_clear_reg, loop_clear_next;
  logic               locked_reg, locked_next;
  logic               timeout_reg, timeout_next;
  logic [SHIFT_W-1:0] kp_reg, kp_next;
  logic [SHIFT_W-1:0] ki_reg, ki_next;
  logic               avg_clear;
  logic               avg_accept;

  assign avg_clear  = (state_reg == ST_IDLE) || (state_reg == ST_CLEAR);
  assign avg_accept = err_valid && ((state_reg == ST_ACQ) || (state_reg == ST_TRACK));

  err_window_avg #(
    .ERR_W    (ERR_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (avg_clear),
    .accept      (avg_accept),
    .phase_error (phase_error),
    .mean_err    (mean_err),
    .mean_valid  (mean_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      good_reg       <= '0;
      bad_reg        <= '0;
      win_reg        <= '0;
      loop_clear_reg <= 1'b0;
      locked_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      kp_reg         <= SHIFT_W'(KP_ACQ_SH);
      ki_reg         <= SHIFT_W'(KI_ACQ_SH);
    end else begin
      state_reg      <= state_next;
      good_reg       <= good_next;
      bad_reg        <= bad_next;
      win_reg        <= win_next;
      loop_clear_reg <= loop_clear_next;
      locked_reg     <= locked_next;
      timeout_reg    <= timeout_next;
      kp_reg         <= kp_next;
      ki_reg         <= ki_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    good_next   = good_reg;
    bad_next    = bad_reg;
    win_next    = win_reg;
    timeout_evt = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_CLEAR;
        ST_CLEAR: begin
          state_next = ST_ACQ;
          good_next  = '0;
          bad_next   = '0;
          win_next   = '0;
        end
        ST_ACQ: begin
          if (restart) begin
            state_next = ST_CLEAR;
          end else if (mean_valid) begin
            good_next = (mean_err < lock_thresh) ? good_reg + GOOD_W'(1) : '0;
            win_next  = win_reg + WIN_W'(1);
            // Lock is tested first so it wins on the timeout window.
            if (good_next == GOOD_W'(LOCK_CNT)) begin
              state_next = ST_TRACK;
              bad_next   = '0;
            end else if (win_next == WIN_W'(ACQ_TIMEOUT)) begin
              state_next  = ST_CLEAR;
              timeout_evt = 1'b1;
            end
          end
        end
        default: begin
          if (restart) begin
            state_next = ST_CLEAR;
          end else if (mean_valid) begin
            bad_next = (mean_err > unlock_thresh) ? bad_reg + BAD_W'(1) : '0;
            if (bad_next == BAD_W'(UNLOCK_CNT)) state_next = ST_CLEAR;
          end
        end
      endcase
    end
  end

  always_comb begin
    loop_clear_next = (state_next == ST_CLEAR);
    locked_next     = (state_next == ST_TRACK);
    timeout_next    = timeout_evt;
    kp_next         = locked_next ? SHIFT_W'(KP_TRK_SH) : SHIFT_W'(KP_ACQ_SH);
    ki_next         = locked_next ? SHIFT_W'(KI_TRK_SH) : SHIFT_W'(KI_ACQ_SH);
  end

  assign state      = state_reg;
  assign loop_clear = loop_clear_reg;
  assign locked     = locked_reg;
  assign timeout    = timeout_reg;
  assign kp_shift   = kp_reg;
  assign ki_shift   = ki_reg;

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Self-checking bench: directed sequences, a window-mean vector table and a
// randomized run compared every cycle against a behavioural model.
module tb_costas_loop_ctrl;

  localparam int ERR_W       = 58;
  localparam int WIN_LOG2    = 2;
  localparam int WIN         = 4;
  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_CNT  = 2;
  localparam int ACQ_TIMEOUT = 6;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic                    restart;
  logic                    err_valid;
  logic signed [ERR_W-1:0] phase_error;
  logic [ERR_W-2:0]        lock_thresh;
  logic [ERR_W-2:0]        unlock_thresh;
  logic [4:0]              kp_shift;
  logic [4:0]              ki_shift;
  logic                    loop_clear;
  logic                    locked;
  logic                    timeout;
  logic [1:0]              state;
  logic [ERR_W-2:0]        mean_err;
  logic                    mean_valid;

  costas_loop_ctrl #(
    .ERR_W       (ERR_W),
    .WIN_LOG2    (WIN_LOG2),
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_CNT  (UNLOCK_CNT),
    .ACQ_TIMEOUT (ACQ_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .restart       (restart),
    .err_valid     (err_valid),
    .phase_error   (phase_error),
    .lock_thresh   (lock_thresh),
    .unlock_thresh (unlock_thresh),
    .kp_shift      (kp_shift),
    .ki_shift      (ki_shift),
    .loop_clear    (loop_clear),
    .locked        (locked),
    .timeout       (timeout),
    .state         (state),
    .mean_err      (mean_err),
    .mean_valid    (mean_valid)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: window as a running sum/count, decisions as rules.
  int     m_state, m_good, m_bad, m_wins, m_n, m_kp, m_ki;
  longint m_sum, m_mean;
  bit     m_mv, m_clear, m_locked, m_to;

  function automatic longint mag(input logic signed [ERR_W-1:0] e);
    longint x;
    x = longint'(e);
    if (x == -(longint'(1) << 57)) return (longint'(1) << 57) - 1;
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_step();
    int nst;
    bit to;
    if (!rst_n) begin
      m_state = 0; m_good = 0; m_bad = 0; m_wins = 0; m_n = 0; m_sum = 0; m_mean = 0;
      m_mv = 0; m_clear = 0; m_locked = 0; m_to = 0; m_kp = 4; m_ki = 8;
      return;
    end
    nst = m_state;
    to  = 1'b0;
    if (!enable)                   nst = 0;
    else if (m_state == 0)         nst = 1;
    else if (m_state == 1)         nst = 2;
    else if (restart)              nst = 1;
    else if (m_mv && m_state == 2) begin
      m_wins++;
      if (m_mean < longint'(lock_thresh)) m_good++; else m_good = 0;
      if (m_good == LOCK_CNT)         nst = 3;
      else if (m_wins == ACQ_TIMEOUT) begin nst = 1; to = 1'b1; end
    end else if (m_mv && m_state == 3) begin
      if (m_mean > longint'(unlock_thresh)) m_bad++; else m_bad = 0;
      if (m_bad == UNLOCK_CNT) nst = 1;
    end
    m_mv = 1'b0;
    if (m_state < 2) begin
      m_n = 0; m_sum = 0;
    end else if (err_valid) begin
      m_sum += mag(phase_error);
      m_n++;
      if (m_n == WIN) begin
        m_mean = m_sum / WIN; m_mv = 1'b1; m_n = 0; m_sum = 0;
      end
    end
    if (nst == 2 && m_state != 2) begin m_good = 0; m_wins = 0; end
    if (nst == 3 && m_state != 3) m_bad = 0;
    m_state  = nst;
    m_clear  = (nst == 1);
    m_locked = (nst == 3);
    m_to     = to;
    m_kp     = m_locked ? 7 : 4;
    m_ki     = m_locked ? 14 : 8;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("model_state", longint'(state), m_state);
      chk("model_loop_clear", longint'(loop_clear), m_clear);
      chk("model_locked", longint'(locked), m_locked);
      chk("model_timeout", longint'(timeout), m_to);
      chk("model_kp", longint'(kp_shift), m_kp);
      chk("model_ki", longint'(ki_shift), m_ki);
      chk("model_mean_valid", longint'(mean_valid), m_mv);
      chk("model_mean_err", longint'(mean_err), m_mean);
    end
  end

  task automatic drive(input bit en, input bit rs, input bit v, input longint e);
    @(posedge clk);
    #1;
    enable      = en;
    restart     = rs;
    err_valid   = v;
    phase_error = ERR_W'(e);
  endtask

  task automatic feed_win(input longint v);
    for (int k = 0; k < WIN; k++) drive(1, 0, 1, (k % 2 == 0) ? v : -v);
  endtask

  typedef struct {
    string  name;
    longint s0, s1, s2, s3;
    longint exp_mean;
  } win_vec_t;

  win_vec_t tbl[7];
  longint   min_e, max_m;

  initial begin
    min_e = -(longint'(1) << 57);
    max_m = (longint'(1) << 57) - 1;
    tbl[0] = '{"most_negative_sat", min_e, min_e, min_e, min_e, max_m};
    tbl[1] = '{"mixed_sign",        8, -8, 4, -4, 6};
    tbl[2] = '{"const_50",          50, -50, 50, 50, 50};
    tbl[3] = '{"truncating_div",    1, 2, -3, 5, 2};
    tbl[4] = '{"max_positive",      max_m, max_m, 1, -1, longint'(1) << 56};
    tbl[5] = '{"rounds_to_zero",    -1, 0, 0, 2, 0};
    tbl[6] = '{"neg_small",         -3, -3, -3, -2, 2};

    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; err_valid = 1'b0; phase_error = '0;
    lock_thresh = 57'd100; unlock_thresh = 57'd200;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", longint'(state), 0);
    chk("rst_kp", longint'(kp_shift), 4);
    chk("rst_ki", longint'(ki_shift), 8);
    chk("rst_loop_clear", longint'(loop_clear), 0);
    chk("rst_locked", longint'(locked), 0);
    chk("rst_timeout", longint'(timeout), 0);
    chk("rst_mean_err", longint'(mean_err), 0);
    chk("rst_mean_valid", longint'(mean_valid), 0);
    $display("TXN reset: state=%0d kp=%0d ki=%0d", state, kp_shift, ki_shift);
    chk_on = 1'b1;
    rst_n  = 1'b1;

    // IDLE -> CLEAR -> ACQ with a single loop_clear cycle
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("en_state_clear", longint'(state), 1);
    chk("en_loop_clear_hi", longint'(loop_clear), 1);
    drive(1, 0, 0, 0);
    chk("en_state_acq", longint'(state), 2);
    chk("en_loop_clear_lo", longint'(loop_clear), 0);
    chk("en_kp_acq", longint'(kp_shift), 4);
    chk("en_ki_acq", longint'(ki_shift), 8);
    $display("TXN enable: state=%0d loop_clear=%0d", state, loop_clear);

    // Four good windows of |err|=50 -> lock two cycles after the 16th sample
    for (int w = 0; w < LOCK_CNT; w++) feed_win(50);
    drive(1, 0, 0, 0);
    chk("lock_mean_valid", longint'(mean_valid), 1);
    chk("lock_mean_err", longint'(mean_err), 50);
    chk("lock_not_yet", longint'(locked), 0);
    drive(1, 0, 0, 0);
    chk("lock_state", longint'(state), 3);
    chk("lock_locked", longint'(locked), 1);
    chk("lock_kp", longint'(kp_shift), 7);
    chk("lock_ki", longint'(ki_shift), 14);
    $display("TXN lock: state=%0d locked=%0d kp=%0d ki=%0d", state, locked, kp_shift, ki_shift);

    // Alternating bad/in-band windows keep lock; two bad in a row drop it
    feed_win(250); feed_win(150); feed_win(250); feed_win(150);
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    chk("hyst_locked", longint'(locked), 1);
    feed_win(250);
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    chk("hyst_one_bad", longint'(state), 3);
    feed_win(250);
    drive(1, 0, 0, 0);
    chk("hyst_mean", longint'(mean_err), 250);
    drive(1, 0, 0, 0);
    chk("unlock_state", longint'(state), 1);
    chk("unlock_clear", longint'(loop_clear), 1);
    chk("unlock_locked", longint'(locked), 0);
    chk("unlock_kp", longint'(kp_shift), 4);
    drive(1, 0, 0, 0);
    chk("unlock_reacq", longint'(state), 2);
    $display("TXN unlock: state=%0d locked=%0d", state, locked);

    // Window mean vectors, each isolated by a restart
    lock_thresh = '0;
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 1, tbl[i].s0);
      drive(1, 0, 1, tbl[i].s1);
      drive(1, 0, 1, tbl[i].s2);
      drive(1, 0, 1, tbl[i].s3);
      drive(1, 0, 0, 0);
      chk({"vec_valid_", tbl[i].name}, longint'(mean_valid), 1);
      chk({"vec_mean_", tbl[i].name}, longint'(mean_err), tbl[i].exp_mean);
      $display("TXN vec %s: mean_err=%0d expected=%0d", tbl[i].name, mean_err, tbl[i].exp_mean);
    end

    // Acquisition timeout after ACQ_TIMEOUT bad windows
    lock_thresh = 57'd100;
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    for (int w = 0; w < ACQ_TIMEOUT; w++) feed_win(500);
    drive(1, 0, 0, 0);
    chk("to_pre_state", longint'(state), 2);
    chk("to_pre_pulse", longint'(timeout), 0);
    drive(1, 0, 0, 0);
    chk("to_state", longint'(state), 1);
    chk("to_pulse", longint'(timeout), 1);
    chk("to_clear", longint'(loop_clear), 1);
    drive(1, 0, 0, 0);
    chk("to_pulse_end", longint'(timeout), 0);
    chk("to_reacq", longint'(state), 2);
    $display("TXN timeout: state=%0d timeout=%0d", state, timeout);

    // Lock reached on the timeout window wins
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    feed_win(500); feed_win(500);
    for (int w = 0; w < LOCK_CNT; w++) feed_win(50);
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    chk("lbt_state", longint'(state), 3);
    chk("lbt_locked", longint'(locked), 1);
    chk("lbt_no_timeout", longint'(timeout), 0);
    chk("lbt_no_clear", longint'(loop_clear), 0);
    $display("TXN lock_beats_timeout: state=%0d timeout=%0d", state, timeout);

    // enable=0 outranks restart: straight to IDLE without loop_clear
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk("prio_idle", longint'(state), 0);
    chk("prio_no_clear", longint'(loop_clear), 0);
    chk("prio_unlocked", longint'(locked), 0);
    drive(1, 0, 0, 0);
    chk("prio_clear", longint'(state), 1);
    drive(1, 0, 0, 0);
    chk("prio_acq", longint'(state), 2);
    $display("TXN priority: state=%0d", state);

    // Restart mid-window discards the partial window
    drive(1, 0, 1, 1000);
    drive(1, 0, 1, -1000);
    drive(1, 1, 1, 1000);
    drive(1, 0, 0, 0);
    chk("rs_clear", longint'(state), 1);
    chk("rs_clear_pulse", longint'(loop_clear), 1);
    feed_win(40);
    drive(1, 0, 0, 0);
    chk("rs_valid", longint'(mean_valid), 1);
    chk("rs_mean", longint'(mean_err), 40);
    $display("TXN restart_mid_window: mean_err=%0d", mean_err);

    // Asynchronous reset mid-window
    drive(1, 0, 1, 77);
    drive(1, 0, 1, 77);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", longint'(state), 0);
    chk("arst_mean", longint'(mean_err), 0);
    chk("arst_kp", longint'(kp_shift), 4);
    chk("arst_valid", longint'(mean_valid), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 0, 0, 0);
    chk("arst_reentry", longint'(state), 1);
    $display("TXN async_reset: state=%0d", state);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      longint m;
      bit en, rs, v;
      if (i % 250 == 0) begin
        lock_thresh   = 57'($urandom_range(60, 140));
        unlock_thresh = lock_thresh + 57'($urandom_range(0, 100));
      end
      en = ($urandom_range(0, 199) != 0);
      rs = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 9) < 7);
      if ((i / 300) % 2 == 0) m = longint'($urandom_range(0, 150));
      else                    m = longint'($urandom_range(100, 400));
      if ($urandom_range(0, 1) == 1) m = -m;
      if ($urandom_range(0, 299) == 0) m = min_e;
      drive(en, rs, v, m);
    end
    drive(1, 0, 0, 0);
    @(negedge clk);
    $display("TXN random: 4000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
